// File: rtl/pe_result_drain.sv
// pe_result_drain: buffers rounded PE results in a small FIFO and groups them
// into tiles on a valid/ready stream. A tile-end flag marks the last entry of
// each tile. The registered hold output keeps enough headroom for the two
// results still in flight in the PE rounder pipeline.
module pe_result_drain #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   pe_valid,
  input  logic [3:0]                             pe_number,
  input  logic [para_int_bits+para_frac_bits-1:0] pe_data,
  input  logic [3:0]                             cfg_count,
  output logic                                   hold,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [para_int_bits+para_frac_bits-1:0] out_data,
  output logic [3:0]                             out_number,
  output logic                                   out_last,
  output logic                                   err_overflow,
  output logic                                   err_range,
  output logic                                   err_dup
);

  localparam int W  = para_int_bits + para_frac_bits;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = W + 5;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] HOLD_LVL = (AW+1)'(FIFO_DEPTH - 2);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  state_t        state;
  state_t        state_next;
  logic [3:0]    tile_n;
  logic [3:0]    tile_n_next;
  logic [3:0]    rcv;
  logic [3:0]    rcv_next;
  logic [7:0]    seen;
  logic [7:0]    seen_next;

  logic          in_range;
  logic          full;
  logic          push;
  logic          pop;
  logic          entry_last;
  logic          dup_hit;
  logic [3:0]    cfg_norm;
  logic [7:0]    num_onehot;
  logic [EW-1:0] head;

  assign in_range   = ~pe_number[3];
  assign full       = (count == FULL_LVL);
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign push       = pe_valid & in_range & (~full | pop);
  assign cfg_norm   = ((cfg_count == 4'd0) || (cfg_count > 4'd8)) ? 4'd8 : cfg_count;
  assign num_onehot = 8'd1 << pe_number[2:0];

  // Head entry is masked while empty so stale storage never shows on the outputs.
  assign head       = mem[rd_ptr];
  assign out_data   = out_valid ? head[W-1:0] : '0;
  assign out_number = out_valid ? head[W+3:W] : 4'd0;
  assign out_last   = out_valid ? head[EW-1] : 1'b0;

  // Occupancy after this cycle's push/pop; feeds both the counter and hold.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Tile tracking: decides the last flag of the entry being pushed and flags duplicates.
  always_comb begin
    state_next  = state;
    tile_n_next = tile_n;
    rcv_next    = rcv;
    seen_next   = seen;
    entry_last  = 1'b0;
    dup_hit     = 1'b0;
    if (push) begin
      unique case (state)
        IDLE: begin
          tile_n_next = cfg_norm;
          rcv_next    = 4'd1;
          seen_next   = num_onehot;
          if (cfg_norm == 4'd1) begin
            entry_last = 1'b1;
          end else begin
            state_next = COLLECT;
          end
        end
        COLLECT: begin
          rcv_next  = rcv + 4'd1;
          dup_hit   = |(seen & num_onehot);
          seen_next = seen | num_onehot;
          if ((rcv + 4'd1) == tile_n) begin
            entry_last = 1'b1;
            seen_next  = 8'd0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Tile state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      tile_n <= 4'd0;
      rcv    <= 4'd0;
      seen   <= 8'd0;
    end else begin
      state  <= state_next;
      tile_n <= tile_n_next;
      rcv    <= rcv_next;
      seen   <= seen_next;
    end
  end

  // FIFO pointers, occupancy, registered hold and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      hold         <= 1'b0;
      err_overflow <= 1'b0;
      err_range    <= 1'b0;
      err_dup      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count        <= count_next;
      hold         <= (count_next >= HOLD_LVL);
      err_overflow <= err_overflow | (pe_valid & in_range & full & ~pop);
      err_range    <= err_range | (pe_valid & ~in_range);
      err_dup      <= err_dup | dup_hit;
    end
  end

  // Entry storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {entry_last, pe_number, pe_data};
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Testbench for pe_result_drain: directed vectors push expected entries into a
// scoreboard queue; a negedge monitor pops and compares every accepted output.
module tb_pe_result_drain;

  logic        clk;
  logic        rst_n;
  logic        pe_valid;
  logic [3:0]  pe_number;
  logic [15:0] pe_data;
  logic [3:0]  cfg_count;
  logic        hold;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_number;
  logic        out_last;
  logic        err_overflow;
  logic        err_range;
  logic        err_dup;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q [$];

  pe_result_drain #(
    .para_int_bits (7),
    .para_frac_bits(9),
    .FIFO_DEPTH    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pe_valid    (pe_valid),
    .pe_number   (pe_number),
    .pe_data     (pe_data),
    .cfg_count   (cfg_count),
    .hold        (hold),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_number  (out_number),
    .out_last    (out_last),
    .err_overflow(err_overflow),
    .err_range   (err_range),
    .err_dup     (err_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every handshake seen at the negedge is one pop at the next posedge.
  always @(negedge clk) begin
    logic [20:0] e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL out_entry: got unexpected last=%0d num=%0d data=%h, expected nothing",
                 out_last, out_number, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_number, out_data} !== e) begin
          errors++;
          $display("[TB] FAIL out_entry: got last=%0d num=%0d data=%h, expected last=%0d num=%0d data=%h",
                   out_last, out_number, out_data, e[20], e[19:16], e[15:0]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] num, input logic [15:0] data,
                               input logic accept, input logic last);
    pe_valid  = 1'b1;
    pe_number = num;
    pe_data   = data;
    if (accept) exp_q.push_back({last, num, data});
    @(posedge clk);
    #1;
    pe_valid  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("[TB] FAIL %s: got %0d entries pending, out_valid=%0d, expected drained",
               name, exp_q.size(), out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n     = 1'b0;
    pe_valid  = 1'b0;
    pe_number = 4'd0;
    pe_data   = 16'd0;
    cfg_count = 4'd4;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_out_data", 32'(out_data), 0);
    checkOutput("reset_out_number", 32'(out_number), 0);
    checkOutput("reset_out_last", 32'(out_last), 0);
    checkOutput("reset_hold", 32'(hold), 0);
    checkOutput("reset_errors", 32'({err_overflow, err_range, err_dup}), 0);
    rst_n = 1'b1;

    $display("[TB] single tile");
    cfg_count = 4'd4;
    out_ready = 1'b1;
    applyStimulus(4'd0, 16'h0100, 1'b1, 1'b0);
    checkOutput("latency_out_valid", 32'(out_valid), 1);
    applyStimulus(4'd1, 16'h0200, 1'b1, 1'b0);
    applyStimulus(4'd2, 16'h0300, 1'b1, 1'b0);
    applyStimulus(4'd3, 16'h0400, 1'b1, 1'b1);
    waitDrain("drain_single_tile");
    checkOutput("single_tile_errors", 32'({err_overflow, err_range, err_dup}), 0);

    $display("[TB] backpressure and hold");
    doReset();
    cfg_count = 4'd8;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(4'(i), 16'h2000 + 16'(i), 1'b1, 1'b0);
    checkOutput("hold_after_5", 32'(hold), 0);
    applyStimulus(4'd5, 16'h2005, 1'b1, 1'b0);
    checkOutput("hold_after_6", 32'(hold), 1);
    applyStimulus(4'd6, 16'h2006, 1'b1, 1'b0);
    applyStimulus(4'd7, 16'h2007, 1'b1, 1'b1);
    checkOutput("full_no_overflow", 32'(err_overflow), 0);
    checkOutput("full_hold", 32'(hold), 1);
    checkOutput("stable_head_number", 32'(out_number), 0);
    checkOutput("stable_head_data", 32'(out_data), 32'h2000);

    $display("[TB] full with simultaneous push and pop");
    out_ready = 1'b1;
    applyStimulus(4'd0, 16'h0A00, 1'b1, 1'b0);
    out_ready = 1'b0;
    checkOutput("simul_no_overflow", 32'(err_overflow), 0);
    checkOutput("simul_out_valid", 32'(out_valid), 1);
    checkOutput("simul_hold", 32'(hold), 1);
    checkOutput("simul_head_number", 32'(out_number), 1);
    checkOutput("simul_head_data", 32'(out_data), 32'h2001);
    applyStimulus(4'd1, 16'h0B00, 1'b0, 1'b0);
    checkOutput("overflow_set", 32'(err_overflow), 1);
    out_ready = 1'b1;
    waitDrain("drain_full");
    checkOutput("hold_after_drain", 32'(hold), 0);

    $display("[TB] range and duplicate");
    doReset();
    checkOutput("overflow_cleared", 32'(err_overflow), 0);
    cfg_count = 4'd3;
    out_ready = 1'b1;
    applyStimulus(4'd2, 16'h0020, 1'b1, 1'b0);
    applyStimulus(4'd9, 16'h0090, 1'b0, 1'b0);
    checkOutput("range_set", 32'(err_range), 1);
    checkOutput("dup_not_yet", 32'(err_dup), 0);
    applyStimulus(4'd2, 16'h0021, 1'b1, 1'b0);
    checkOutput("dup_set", 32'(err_dup), 1);
    applyStimulus(4'd5, 16'h0050, 1'b1, 1'b1);
    waitDrain("drain_range_dup");
    checkOutput("range_dup_no_overflow", 32'(err_overflow), 0);

    $display("[TB] tile size normalisation");
    doReset();
    cfg_count = 4'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(4'(i), 16'h1000 + 16'(i), 1'b1, (i == 7));
    waitDrain("drain_count0");
    cfg_count = 4'd1;
    applyStimulus(4'd0, 16'h7FFF, 1'b1, 1'b1);
    applyStimulus(4'd3, 16'h1234, 1'b1, 1'b1);
    waitDrain("drain_count1");
    checkOutput("norm_errors", 32'({err_overflow, err_range, err_dup}), 0);

    $display("[TB] mid-tile reset");
    doReset();
    cfg_count = 4'd4;
    out_ready = 1'b0;
    applyStimulus(4'd0, 16'h3000, 1'b0, 1'b0);
    applyStimulus(4'd1, 16'h3001, 1'b0, 1'b0);
    checkOutput("pre_reset_out_valid", 32'(out_valid), 1);
    doReset();
    checkOutput("midreset_out_valid", 32'(out_valid), 0);
    checkOutput("midreset_out_data", 32'(out_data), 0);
    checkOutput("midreset_out_number", 32'(out_number), 0);
    checkOutput("midreset_out_last", 32'(out_last), 0);
    checkOutput("midreset_hold", 32'(hold), 0);
    out_ready = 1'b1;
    applyStimulus(4'd4, 16'h4004, 1'b1, 1'b0);
    applyStimulus(4'd5, 16'h4005, 1'b1, 1'b0);
    applyStimulus(4'd6, 16'h4006, 1'b1, 1'b0);
    applyStimulus(4'd7, 16'h4007, 1'b1, 1'b1);
    waitDrain("drain_midreset");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
